// File: rtl/cr_lz77_comp_sym_ser_pkg.sv
// Shared types for the LZ77 compressor symbol serialiser: token lane types,
// the registered output symbol and the serialiser FSM states.
package cr_lz77_comp_sym_ser_pkg;

  typedef enum logic [1:0] {
    TOK_NONE = 2'd0,
    TOK_LIT  = 2'd1,
    TOK_MTCH = 2'd2,
    TOK_RSVD = 2'd3
  } lz_tok_type_e;

  typedef struct packed {
    logic [1:0]  typ;
    logic [7:0]  data;
    logic [15:0] len;
    logic [15:0] ofs;
  } lz_sym_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LANES = 2'd1,
    ST_EOT   = 2'd2
  } sym_ser_state_e;

  localparam logic [1:0] SYM_LIT  = 2'd1;
  localparam logic [1:0] SYM_MTCH = 2'd2;
  localparam logic [1:0] SYM_EOT  = 2'd3;

endpackage

// File: rtl/cr_lz77_comp_sym_ser_if.sv
// Token-beat input stream and serialised symbol output stream of the
// symbol serialiser; master is the environment side, slave the serialiser.
interface cr_lz77_comp_sym_ser_if;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  in_type;
  logic [31:0] in_literal;
  logic [15:0] in_mtch_len;
  logic [15:0] in_mtch_ofs;
  logic        in_eot;
  logic        sym_vld;
  logic        sym_rdy;
  logic [1:0]  sym_type;
  logic [7:0]  sym_data;
  logic [15:0] sym_len;
  logic [15:0] sym_ofs;

  modport master (
    output in_vld, in_type, in_literal, in_mtch_len, in_mtch_ofs, in_eot, sym_rdy,
    input  in_rdy, sym_vld, sym_type, sym_data, sym_len, sym_ofs
  );

  modport slave (
    input  in_vld, in_type, in_literal, in_mtch_len, in_mtch_ofs, in_eot, sym_rdy,
    output in_rdy, sym_vld, sym_type, sym_data, sym_len, sym_ofs
  );
endinterface

// File: rtl/cr_lz77_comp_sym_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module cr_lz77_comp_sym_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cr_lz77_comp_sym_ser.sv
// Serialises LZ77 token beats (up to LANES literals or one match, plus EOT)
// into one registered symbol per cycle and keeps saturating event counters.
module cr_lz77_comp_sym_ser
  import cr_lz77_comp_sym_ser_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cr_lz77_comp_sym_ser_if.slave tok,
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      lit_cnt,
  output logic [CNT_W-1:0]      mtch_cnt,
  output logic [CNT_W-1:0]      eot_cnt,
  output logic                  tok_err
);

  localparam int LW = $clog2(LANES);

  sym_ser_state_e state, state_nx;

  logic [2*LANES-1:0] h_type;
  logic [8*LANES-1:0] h_lit;
  logic [15:0]        h_len, h_ofs;
  logic               h_eot;
  logic [LANES-1:0]   h_mask;

  logic [LANES-1:0]   in_mask;
  logic               in_err, seen_mtch;

  logic               in_rdy_c, acc, load_ok, cur_active, cur_eot;
  logic [LANES-1:0]   cur_mask, rem_mask;
  logic [2*LANES-1:0] cur_type;
  logic [8*LANES-1:0] cur_lit;
  logic [15:0]        cur_len, cur_ofs;
  logic [LW-1:0]      lane_idx;
  logic [1:0]         lane_type;

  lz_sym_t            sym_nx, sym_p1;
  logic               sym_vld_nx, sym_vld_p1, sym_load, sym_hs;
  logic               tok_err_p1;

  // Pending-lane mask of an incoming beat: only the lowest match lane survives.
  always_comb begin
    in_mask   = '0;
    in_err    = 1'b0;
    seen_mtch = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      case (tok.in_type[2*i +: 2])
        TOK_LIT:  in_mask[i] = 1'b1;
        TOK_MTCH: begin
          if (seen_mtch) in_err = 1'b1;
          else           in_mask[i] = 1'b1;
          seen_mtch = 1'b1;
        end
        TOK_RSVD: in_err = 1'b1;
        default:  ;
      endcase
    end
  end

  // Stage p0: pick the source beat (bypassed input or held beat) and its lowest lane.
  always_comb begin
    in_rdy_c   = rst_n && (state == ST_IDLE);
    acc        = tok.in_vld && in_rdy_c;
    load_ok    = !sym_vld_p1 || tok.sym_rdy;
    cur_active = acc || (state != ST_IDLE);
    cur_mask   = acc ? in_mask         : h_mask;
    cur_type   = acc ? tok.in_type     : h_type;
    cur_lit    = acc ? tok.in_literal  : h_lit;
    cur_len    = acc ? tok.in_mtch_len : h_len;
    cur_ofs    = acc ? tok.in_mtch_ofs : h_ofs;
    cur_eot    = acc ? tok.in_eot      : h_eot;

    lane_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (cur_mask[i]) lane_idx = LW'(i);
    end
    lane_type = cur_type[2*lane_idx +: 2];

    state_nx   = state;
    rem_mask   = cur_mask;
    sym_nx     = '0;
    sym_vld_nx = sym_vld_p1;
    sym_load   = 1'b0;

    if (load_ok) begin
      sym_load   = 1'b1;
      sym_vld_nx = 1'b0;
      if (cur_mask != '0) begin
        sym_vld_nx         = 1'b1;
        rem_mask[lane_idx] = 1'b0;
        if (lane_type == TOK_LIT) begin
          sym_nx.typ  = SYM_LIT;
          sym_nx.data = cur_lit[8*lane_idx +: 8];
        end else begin
          sym_nx.typ = SYM_MTCH;
          sym_nx.len = cur_len;
          sym_nx.ofs = cur_ofs;
        end
        if (rem_mask != '0) state_nx = ST_LANES;
        else if (cur_eot)   state_nx = ST_EOT;
        else                state_nx = ST_IDLE;
      end else if (cur_active && cur_eot) begin
        sym_vld_nx = 1'b1;
        sym_nx.typ = SYM_EOT;
        state_nx   = ST_IDLE;
      end else begin
        state_nx = ST_IDLE;
      end
    end else if (acc) begin
      if (in_mask != '0)   state_nx = ST_LANES;
      else if (tok.in_eot) state_nx = ST_EOT;
      else                 state_nx = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Stage p1: registered symbol, pending mask and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_mask     <= '0;
      sym_vld_p1 <= 1'b0;
      sym_p1     <= '0;
      tok_err_p1 <= 1'b0;
    end else begin
      h_mask     <= rem_mask;
      sym_vld_p1 <= sym_vld_nx;
      tok_err_p1 <= acc && in_err;
      if (sym_load) sym_p1 <= sym_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      h_type <= tok.in_type;
      h_lit  <= tok.in_literal;
      h_len  <= tok.in_mtch_len;
      h_ofs  <= tok.in_mtch_ofs;
      h_eot  <= tok.in_eot;
    end
  end

  assign sym_hs       = sym_vld_p1 && tok.sym_rdy;
  assign tok.in_rdy   = in_rdy_c;
  assign tok.sym_vld  = sym_vld_p1;
  assign tok.sym_type = sym_p1.typ;
  assign tok.sym_data = sym_p1.data;
  assign tok.sym_len  = sym_p1.len;
  assign tok.sym_ofs  = sym_p1.ofs;
  assign tok_err      = tok_err_p1;

  cr_lz77_comp_sym_cnt #(.CNT_W(CNT_W)) u_lit_cnt (
    .clk (clk), .rst_n (rst_n), .clr (stat_clr),
    .inc (sym_hs && (sym_p1.typ == SYM_LIT)), .cnt (lit_cnt)
  );

  cr_lz77_comp_sym_cnt #(.CNT_W(CNT_W)) u_mtch_cnt (
    .clk (clk), .rst_n (rst_n), .clr (stat_clr),
    .inc (sym_hs && (sym_p1.typ == SYM_MTCH)), .cnt (mtch_cnt)
  );

  cr_lz77_comp_sym_cnt #(.CNT_W(CNT_W)) u_eot_cnt (
    .clk (clk), .rst_n (rst_n), .clr (stat_clr),
    .inc (sym_hs && (sym_p1.typ == SYM_EOT)), .cnt (eot_cnt)
  );

endmodule
